// File: rtl/nl_regs_pkg.sv
// Shared register-map constants and types for the NL engine register file.
package nl_regs_pkg;

  localparam int OFS_CTRL   = 'h20;
  localparam int OFS_STATUS = 'h21;
  localparam int OFS_IRQ_EN = 'h22;

  localparam int CTRL_COMMIT     = 0;
  localparam int CTRL_CLR_SHADOW = 1;

  localparam int STAT_PENDING = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;

  typedef struct packed {
    logic err;
    logic done;
    logic pending;
  } status_t;

  // CFG and STAT windows must fit below the CTRL block.
  function automatic bit map_fits(int n_cfg, int n_stat);
    return (n_cfg >= 1) && (n_cfg <= 16) && (n_stat >= 1) && (n_stat <= 15) &&
           ((n_cfg + n_stat) < OFS_CTRL);
  endfunction

endpackage

// File: rtl/regfile_nl_gen_if.sv
// Host register bus between the bus master and the NL register file.
interface regfile_nl_gen_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
);
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              rd_valid;

  modport master (output wr_en, rd_en, addr, write_data, input read_data, rd_valid);
  modport slave  (input wr_en, rd_en, addr, write_data, output read_data, rd_valid);
endinterface

// File: rtl/regfile_shadow_reg.sv
// One shadow/active configuration register pair; the active copy loads only on commit.
module regfile_shadow_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] shadow,
  output logic [DATA_W-1:0] active
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (clr)
        shadow <= '0;
      else if (we)
        shadow <= din;
      // load sees the pre-write shadow, so a same-cycle host write stays pending
      if (load)
        active <= shadow;
    end
  end

endmodule

// File: rtl/regfile_nl_gen.sv
// Double-buffered NL engine register file: shadow/active config, status, W1C flags, IRQ.
module regfile_nl_gen
  import nl_regs_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 14'h300,
  parameter int                N_CFG     = 8,
  parameter int                N_STAT    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_nl_gen_if.slave          bus,
  output logic [N_CFG*DATA_W-1:0]  cfg_active,
  output logic                     cfg_update,
  input  logic                     engine_idle,
  input  logic [N_STAT*DATA_W-1:0] stat_in,
  input  logic                     done_pulse,
  input  logic                     err_pulse,
  output logic                     irq
);

  if (!map_fits(N_CFG, N_STAT)) begin : g_map_check
    $error("regfile_nl_gen: N_CFG/N_STAT out of range or overlap the CTRL block");
  end

  logic [ADDR_W-1:0] offset;
  logic              wr_ctrl, wr_status, wr_irq_en;
  logic              commit_req, clr_shadow, xfer;
  status_t           flags_q;
  logic [1:0]        irq_en_q;
  logic [DATA_W-1:0] shadow_q [N_CFG];
  logic [DATA_W-1:0] rd_mux;

  assign offset     = bus.addr - BASE_ADDR;
  assign wr_ctrl    = bus.wr_en && (offset == ADDR_W'(OFS_CTRL));
  assign wr_status  = bus.wr_en && (offset == ADDR_W'(OFS_STATUS));
  assign wr_irq_en  = bus.wr_en && (offset == ADDR_W'(OFS_IRQ_EN));
  assign commit_req = wr_ctrl && bus.write_data[CTRL_COMMIT];
  assign clr_shadow = wr_ctrl && bus.write_data[CTRL_CLR_SHADOW];
  assign xfer       = flags_q.pending && engine_idle;

  for (genvar k = 0; k < N_CFG; k++) begin : g_cfg
    logic we_k;
    assign we_k = bus.wr_en && (offset == ADDR_W'(k + 1));

    regfile_shadow_reg #(.DATA_W(DATA_W)) u_reg (
      .clk    (clk),
      .rst    (rst),
      .we     (we_k),
      .clr    (clr_shadow),
      .load   (xfer),
      .din    (bus.write_data),
      .shadow (shadow_q[k]),
      .active (cfg_active[k*DATA_W +: DATA_W])
    );
  end

  // A pending commit absorbs further COMMIT writes until it transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q    <= '0;
      irq_en_q   <= '0;
      cfg_update <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (xfer)
        flags_q.pending <= 1'b0;
      else if (commit_req)
        flags_q.pending <= 1'b1;
      flags_q.done <= done_pulse || (flags_q.done && !(wr_status && bus.write_data[STAT_DONE]));
      flags_q.err  <= err_pulse  || (flags_q.err  && !(wr_status && bus.write_data[STAT_ERR]));
      if (wr_irq_en)
        irq_en_q <= bus.write_data[STAT_ERR:STAT_DONE];
      cfg_update <= xfer;
      irq        <= |({flags_q.err, flags_q.done} & irq_en_q);
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_CFG; k++)
      if (offset == ADDR_W'(k + 1))
        rd_mux = shadow_q[k];
    for (int j = 0; j < N_STAT; j++)
      if (offset == ADDR_W'(N_CFG + 1 + j))
        rd_mux = stat_in[j*DATA_W +: DATA_W];
    if (offset == ADDR_W'(OFS_STATUS)) begin
      rd_mux[STAT_PENDING] = flags_q.pending;
      rd_mux[STAT_DONE]    = flags_q.done;
      rd_mux[STAT_ERR]     = flags_q.err;
    end
    if (offset == ADDR_W'(OFS_IRQ_EN))
      rd_mux[STAT_ERR:STAT_DONE] = irq_en_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.read_data <= '0;
      bus.rd_valid  <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en)
        bus.read_data <= rd_mux;
    end
  end

endmodule
